sram_ctrl: RTL and testbench
============================

SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 18, SRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, SRAM data width, two byte lanes.
REQ-003 SHALL have parameter RD_CYCLES, default 2, clocks with OE_/CE_ asserted before read data is sampled.
REQ-004 SHALL have parameter WR_CYCLES, default 2, clocks with WE_ held low.
REQ-005 SHALL have port clk, input, 1, single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port req_valid, input, 1, request present.
REQ-008 SHALL have port req_ready, output, 1, controller can accept a request.
REQ-009 SHALL have port req_we, input, 1, 1 = write, 0 = read.
REQ-010 SHALL have port req_addr, input, ADDR_W, word address.
REQ-011 SHALL have port req_wdata, input, DATA_W, write data.
REQ-012 SHALL have port req_be, input, 2, byte enables: bit0 = low byte, bit1 = high byte.
REQ-013 SHALL have port rsp_valid, output, 1, one-cycle completion pulse.
REQ-014 SHALL have port rsp_rdata, output, DATA_W, read data, valid only while rsp_valid is high.
REQ-015 SHALL have port sram_a, output, ADDR_W, SRAM address.
REQ-016 SHALL have ports sram_dq_o, output, DATA_W, and sram_dq_oe, output, 1, SRAM data out and its drive enable; the tristate pad sits in the board top.
REQ-017 SHALL have port sram_dq_i, input, DATA_W, SRAM data in.
REQ-018 SHALL have ports sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n, outputs, 1 each, active-low SRAM strobes.

Function
REQ-019 SHALL drive every sram_* output from a flop, with no combinational path from the req_* inputs.
REQ-020 SHALL implement the states IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD.
REQ-021 SHALL assert req_ready only in IDLE; a request is accepted on a clk edge where req_valid and req_ready are both high, and all req_* fields are captured at that edge.
REQ-022 SHALL, for a read accepted at edge N, hold sram_a = addr, ce_n = 0, oe_n = 0 and lb_n/ub_n = ~be for cycles N+1..N+RD_CYCLES.
REQ-023 SHALL, for a read, register sram_dq_i at the end of cycle N+RD_CYCLES and pulse rsp_valid in cycle N+RD_CYCLES+1; byte lanes with be = 0 return 0.
REQ-024 SHALL, for a write accepted at edge N, enter WR_SETUP for 1 cycle: address, ce_n = 0, lb/ub asserted, dq_oe = 1, we_n = 1.
REQ-025 SHALL then enter WR_PULSE for WR_CYCLES cycles with we_n = 0.
REQ-026 SHALL then enter WR_HOLD for 1 cycle with we_n = 1 while address, data, CE and byte strobes stay stable, and pulse rsp_valid with rsp_rdata = 0 in that cycle.
REQ-027 SHALL keep sram_oe_n = 1 throughout writes.
REQ-028 SHALL never have sram_dq_oe = 1 and sram_oe_n = 0 in the same cycle.
REQ-029 SHALL have at least one IDLE cycle, with all strobes deasserted and dq_oe = 0, between consecutive accesses.
REQ-030 SHALL give read latency RD_CYCLES+1 from acceptance to rsp_valid, and write latency WR_CYCLES+2.
REQ-031 SHALL, for req_be = 0, follow the normal timing and pulse rsp_valid, but with lb_n = ub_n = 1 and rdata = 0.
REQ-032 SHALL ignore req_* changes after acceptance, and SHALL ignore req_valid outside IDLE.
REQ-033 SHALL implement a cycle counter of width $clog2(max(RD_CYCLES,WR_CYCLES)+1), reloaded on entry to RD and to WR_PULSE.
REQ-034 SHALL raise an elaboration error if RD_CYCLES < 1 or WR_CYCLES < 1.

Reset
REQ-035 SHALL, on rst at a clk edge, set: state = IDLE; req_ready = 1 in the following cycle; rsp_valid = 0; rsp_rdata = 0; sram_a = 0; sram_dq_o = 0; sram_dq_oe = 0; all *_n strobes = 1.
REQ-036 SHALL, if rst is asserted mid-access, abort the access at that edge: strobes deasserted next cycle, no rsp_valid issued for the aborted request.

Structure
REQ-037 SHALL define the state enum and the default ADDR_W/DATA_W constants in shared package sram_pkg.
REQ-038 SHALL be a single module with no sub-module.

Verification
REQ-039 SHALL check, with RD_CYCLES = 2 against a 10 ns async SRAM model at 100 MHz: write 0xA55A to address 0x00010, then read 0x00010 -> rsp_rdata = 0xA55A, 3 cycles after acceptance.
REQ-040 SHALL check: write 0x1234 be = 11, then write 0xFFFF be = 01 to address 0x3FFFF, then read -> 0x12FF.
REQ-041 SHALL check: a read with be = 10 of a word containing 0xBEEF -> 0xBE00.
REQ-042 SHALL check: req_valid held high for 4 back-to-back reads -> one accept every 3 cycles, strobes high for 1 cycle between accesses.
REQ-043 SHALL check: rst asserted during the WR_PULSE of a write of 0x7777 -> we_n = 1 next cycle, no rsp_valid, req_ready = 1.
REQ-044 SHALL run an assertion throughout all scenarios that sram_dq_oe and ~sram_oe_n are never both high.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared constants and FSM state encoding for the async SRAM controller.
package sram_pkg;

   localparam int DEF_ADDR_W = 18;
   localparam int DEF_DATA_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD       = 3'd1,
      ST_WR_SETUP = 3'd2,
      ST_WR_PULSE = 3'd3,
      ST_WR_HOLD  = 3'd4
   } sram_state_e;

endpackage

// File: rtl/sram_ctrl.sv
// Single-port controller for a 16-bit async SRAM with byte lanes.
// Every sram_* pin comes straight from a flop; one request is in flight at a time.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// ST_IDLE     | strobes off, bus released, req_ready high
// ST_RD       | CE/OE low for RD_CYCLES clocks, data sampled on the last edge
// ST_WR_SETUP | address/data/CE/lanes driven, WE still high (1 clock)
// ST_WR_PULSE | WE low for WR_CYCLES clocks
// ST_WR_HOLD  | WE high, address/data/CE/lanes stable, rsp_valid pulsed
module sram_ctrl
   import sram_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int RD_CYCLES = 2,
   parameter int WR_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [1:0]        req_be,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] sram_a,
   output logic [DATA_W-1:0] sram_dq_o,
   output logic              sram_dq_oe,
   input  logic [DATA_W-1:0] sram_dq_i,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   output logic              sram_lb_n,
   output logic              sram_ub_n
);

   localparam int LANE_W  = DATA_W / 2;
   localparam int MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);
   localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   if (RD_CYCLES < 1 || WR_CYCLES < 1) begin : g_bad_cycles
      $error("sram_ctrl: RD_CYCLES and WR_CYCLES must both be at least 1");
   end

   sram_state_e       r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [1:0]        r_be;
   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_rdata;
   logic [ADDR_W-1:0] r_a;
   logic [DATA_W-1:0] r_dq_o;
   logic              r_dq_oe;
   logic              r_ce_n;
   logic              r_oe_n;
   logic              r_we_n;
   logic              r_lb_n;
   logic              r_ub_n;

   logic [DATA_W-1:0] w_lane_mask;
   logic              w_cnt_done;

   // Disabled lanes read back as zero regardless of what the SRAM drives.
   assign w_lane_mask = {{LANE_W{r_be[1]}}, {LANE_W{r_be[0]}}};
   assign w_cnt_done  = (r_cnt == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_be        <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_a         <= '0;
         r_dq_o      <= '0;
         r_dq_oe     <= 1'b0;
         r_ce_n      <= 1'b1;
         r_oe_n      <= 1'b1;
         r_we_n      <= 1'b1;
         r_lb_n      <= 1'b1;
         r_ub_n      <= 1'b1;
      end else begin
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         unique case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_a    <= req_addr;
                  r_be   <= req_be;
                  r_ce_n <= 1'b0;
                  r_lb_n <= ~req_be[0];
                  r_ub_n <= ~req_be[1];
                  if (req_we) begin
                     r_dq_o  <= req_wdata;
                     r_dq_oe <= 1'b1;
                     r_state <= ST_WR_SETUP;
                  end else begin
                     r_oe_n  <= 1'b0;
                     r_cnt   <= RD_LOAD;
                     r_state <= ST_RD;
                  end
               end
            end
            ST_RD: begin
               if (w_cnt_done) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_rdata <= sram_dq_i & w_lane_mask;
                  r_ce_n      <= 1'b1;
                  r_oe_n      <= 1'b1;
                  r_lb_n      <= 1'b1;
                  r_ub_n      <= 1'b1;
                  r_state     <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt - CNT_ONE;
               end
            end
            ST_WR_SETUP: begin
               r_we_n  <= 1'b0;
               r_cnt   <= WR_LOAD;
               r_state <= ST_WR_PULSE;
            end
            ST_WR_PULSE: begin
               if (w_cnt_done) begin
                  r_we_n      <= 1'b1;
                  r_rsp_valid <= 1'b1;
                  r_state     <= ST_WR_HOLD;
               end else begin
                  r_cnt <= r_cnt - CNT_ONE;
               end
            end
            ST_WR_HOLD: begin
               r_dq_oe <= 1'b0;
               r_ce_n  <= 1'b1;
               r_lb_n  <= 1'b1;
               r_ub_n  <= 1'b1;
               r_state <= ST_IDLE;
            end
            default: begin
               r_dq_oe <= 1'b0;
               r_ce_n  <= 1'b1;
               r_oe_n  <= 1'b1;
               r_we_n  <= 1'b1;
               r_lb_n  <= 1'b1;
               r_ub_n  <= 1'b1;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready  = (r_state == ST_IDLE);
   assign rsp_valid  = r_rsp_valid;
   assign rsp_rdata  = r_rsp_rdata;
   assign sram_a     = r_a;
   assign sram_dq_o  = r_dq_o;
   assign sram_dq_oe = r_dq_oe;
   assign sram_ce_n  = r_ce_n;
   assign sram_oe_n  = r_oe_n;
   assign sram_we_n  = r_we_n;
   assign sram_lb_n  = r_lb_n;
   assign sram_ub_n  = r_ub_n;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl against a behavioural 10 ns async SRAM at 100 MHz.
module tb_sram_ctrl;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [17:0] req_addr;
   logic [15:0] req_wdata;
   logic [1:0]  req_be;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic [17:0] sram_a;
   logic [15:0] sram_dq_o;
   logic        sram_dq_oe;
   logic [15:0] sram_dq_i;
   logic        sram_ce_n;
   logic        sram_oe_n;
   logic        sram_we_n;
   logic        sram_lb_n;
   logic        sram_ub_n;

   int n_vec  = 0;
   int n_miss = 0;

   logic [15:0] mem [0:(1<<18)-1];
   int          mem_tick = 0;

   sram_ctrl #(
      .ADDR_W(18), .DATA_W(16), .RD_CYCLES(2), .WR_CYCLES(2)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .sram_a(sram_a), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
      .sram_dq_i(sram_dq_i),
      .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
      .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // SRAM model: write commits on the rising edge of WE while CE is low.
   always @(posedge sram_we_n) begin
      if (!sram_ce_n && sram_dq_oe) begin
         if (!sram_lb_n) mem[sram_a][7:0]  = sram_dq_o[7:0];
         if (!sram_ub_n) mem[sram_a][15:8] = sram_dq_o[15:8];
         mem_tick++;
      end
   end

   // Read data goes garbage on any change and settles 10 ns later.
   always @(sram_a or sram_ce_n or sram_oe_n or mem_tick) begin
      sram_dq_i <= 16'hDEAD;
      sram_dq_i <= #10 ((!sram_ce_n && !sram_oe_n) ? mem[sram_a] : 16'hDEAD);
   end

   always @(negedge clk) begin
      chk("dq_oe_with_oe", {31'd0, sram_dq_oe & ~sram_oe_n}, 32'd0);
   end

   initial begin
      #200us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic access(input logic we, input logic [17:0] addr, input logic [15:0] wd,
                         input logic [1:0] be, input logic [15:0] exp);
      int lat;
      int exp_lat;
      exp_lat = we ? 4 : 3;
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
      lat = 0;
      @(negedge clk);
      while (!req_ready && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("ready_wait", {31'd0, lat < 20}, 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0; req_we = ~we; req_addr = ~addr; req_wdata = ~wd; req_be = ~be;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat < exp_lat) begin
            chk("acc_addr", {14'd0, sram_a}, {14'd0, addr});
            chk("acc_ce_n", {31'd0, sram_ce_n}, 32'd0);
            chk("acc_lb_n", {31'd0, sram_lb_n}, {31'd0, ~be[0]});
            chk("acc_ub_n", {31'd0, sram_ub_n}, {31'd0, ~be[1]});
            chk("acc_oe_n", {31'd0, sram_oe_n}, {31'd0, we});
            chk("acc_dq_oe", {31'd0, sram_dq_oe}, {31'd0, we});
            chk("acc_ready", {31'd0, req_ready}, 32'd0);
            if (we) begin
               chk("wr_we_n", {31'd0, sram_we_n}, (lat == 1) ? 32'd1 : 32'd0);
               chk("wr_dq_o", {16'd0, sram_dq_o}, {16'd0, wd});
            end else begin
               chk("rd_we_n", {31'd0, sram_we_n}, 32'd1);
            end
         end
      end while (!rsp_valid && lat < 20);
      chk("latency", lat, exp_lat);
      chk("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, exp});
      if (we) begin
         chk("hold_we_n", {31'd0, sram_we_n}, 32'd1);
         chk("hold_ce_n", {31'd0, sram_ce_n}, 32'd0);
         chk("hold_addr", {14'd0, sram_a}, {14'd0, addr});
         chk("hold_dq_o", {16'd0, sram_dq_o}, {16'd0, wd});
      end
      @(negedge clk);
      chk("gap_strobes", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}, 32'h1F);
      chk("gap_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
      chk("gap_rsp", {31'd0, rsp_valid}, 32'd0);
      chk("gap_ready", {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      logic [15:0] b2b_exp [0:3];
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
      req_addr = '0; req_wdata = '0; req_be = 2'b00;
      for (int i = 0; i < (1<<18); i++) mem[i] = 16'h0000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_strobes", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}, 32'h1F);
      chk("rst_rsp", {15'd0, rsp_valid, rsp_rdata}, 32'd0);
      chk("rst_addr", {14'd0, sram_a}, 32'd0);
      chk("rst_dq", {15'd0, sram_dq_oe, sram_dq_o}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      access(1'b1, 18'h00010, 16'hA55A, 2'b11, 16'h0000);
      access(1'b0, 18'h00010, 16'h0000, 2'b11, 16'hA55A);

      access(1'b1, 18'h3FFFF, 16'h1234, 2'b11, 16'h0000);
      access(1'b1, 18'h3FFFF, 16'hFFFF, 2'b01, 16'h0000);
      access(1'b0, 18'h3FFFF, 16'h0000, 2'b11, 16'h12FF);

      access(1'b1, 18'h00020, 16'hBEEF, 2'b11, 16'h0000);
      access(1'b0, 18'h00020, 16'h0000, 2'b10, 16'hBE00);
      access(1'b0, 18'h00020, 16'h0000, 2'b01, 16'h00EF);
      access(1'b0, 18'h00020, 16'h0000, 2'b00, 16'h0000);
      access(1'b1, 18'h00020, 16'h0000, 2'b00, 16'h0000);
      access(1'b0, 18'h00020, 16'h0000, 2'b11, 16'hBEEF);

      // Back-to-back reads with req_valid held: accept, RD, RD, IDLE+rsp, accept...
      mem[18'h00100] = 16'h1111; mem[18'h00101] = 16'h2222;
      mem[18'h00102] = 16'h3333; mem[18'h00103] = 16'h4444;
      b2b_exp[0] = 16'h1111; b2b_exp[1] = 16'h2222;
      b2b_exp[2] = 16'h3333; b2b_exp[3] = 16'h4444;
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b0; req_be = 2'b11; req_addr = 18'h00100;
      for (int k = 0; k <= 12; k++) begin
         @(negedge clk);
         chk("b2b_ready", {31'd0, req_ready}, (k % 3 == 0) ? 32'd1 : 32'd0);
         chk("b2b_ce_n", {31'd0, sram_ce_n}, (k % 3 == 0) ? 32'd1 : 32'd0);
         chk("b2b_rsp", {31'd0, rsp_valid}, (k % 3 == 0 && k > 0) ? 32'd1 : 32'd0);
         if (k % 3 == 0 && k > 0)
            chk("b2b_rdata", {16'd0, rsp_rdata}, {16'd0, b2b_exp[k/3 - 1]});
         if (k % 3 == 0 && k < 12) req_addr = 18'h00100 + 18'(k / 3);
         if (k == 9) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
         end
      end

      // Reset in the middle of a write pulse.
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b1; req_addr = 18'h00055; req_wdata = 16'h7777; req_be = 2'b11;
      @(negedge clk);
      chk("abort_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("abort_setup_we_n", {31'd0, sram_we_n}, 32'd1);
      @(negedge clk);
      chk("abort_pulse_we_n", {31'd0, sram_we_n}, 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_we_n", {31'd0, sram_we_n}, 32'd1);
      chk("abort_strobes", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}, 32'h1F);
      chk("abort_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
      chk("abort_ready_after", {31'd0, req_ready}, 32'd1);
      for (int i = 0; i < 6; i++) begin
         chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
         @(negedge clk);
      end

      access(1'b0, 18'h00010, 16'h0000, 2'b11, 16'hA55A);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
